// File: rtl/lsu_mw_controller.sv
// Memory/writeback load-store controller: decodes the MW-stage instruction, runs one req/ack
// data-memory access per instruction, stalls MW until it completes and returns extended load data.
module lsu_mw_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  InstF_MW_opcode,
  input  logic [2:0]  InstF_MW_funct3,
  input  logic [31:0] addr_MW,
  input  logic [31:0] wdata_MW,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        Stall_MW,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_fault
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d, we_q, we_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     ldata_q, ldata_d;
  logic            lvalid_q, lvalid_d, fault_q, fault_d;

  logic        is_load, is_store, is_mem, addr_mis;
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec, rd_shift, ext_data;
  logic [15:0] rd_half;

  always_comb begin
    is_load  = (InstF_MW_opcode == 7'b0000011) &&
               (InstF_MW_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    is_store = (InstF_MW_opcode == 7'b0100011) &&
               (InstF_MW_funct3 inside {3'b000, 3'b001, 3'b010});
    is_mem   = is_load || is_store;
    addr_mis = ((InstF_MW_funct3[1:0] == 2'b01) && addr_MW[0]) ||
               ((InstF_MW_funct3[1:0] == 2'b10) && (addr_MW[1:0] != 2'b00));
    case (InstF_MW_funct3[1:0])
      2'b00: begin
        be_dec    = 4'b0001 << addr_MW[1:0];
        wdata_dec = {4{wdata_MW[7:0]}};
      end
      2'b01: begin
        be_dec    = 4'b0011 << {addr_MW[1], 1'b0};
        wdata_dec = {2{wdata_MW[15:0]}};
      end
      default: begin
        be_dec    = 4'b1111;
        wdata_dec = wdata_MW;
      end
    endcase
  end

  // Lane extraction uses the address/funct3 latched at issue, not the live MW inputs.
  always_comb begin
    rd_shift = mem_rdata >> {lane_q, 3'b000};
    rd_half  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ext_data = {24'h0, rd_shift[7:0]};
      3'b001:  ext_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  ext_data = {16'h0, rd_half};
      default: ext_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    f3_d       = f3_q;
    lane_d     = lane_q;
    ldata_d    = ldata_q;
    lvalid_d   = 1'b0;
    fault_d    = 1'b0;
    Stall_MW   = 1'b0;
    misaligned = 1'b0;
    unique case (state_q)
      StIdle: begin
        misaligned = is_mem && addr_mis;
        if (is_mem && !addr_mis) begin
          Stall_MW = 1'b1;
          state_d  = StWait;
          cnt_d    = '0;
          req_d    = 1'b1;
          we_d     = is_store;
          addr_d   = {addr_MW[31:2], 2'b00};
          wdata_d  = wdata_dec;
          be_d     = be_dec;
          f3_d     = InstF_MW_funct3;
          lane_d   = addr_MW[1:0];
        end
      end
      StWait: begin
        Stall_MW = 1'b1;
        cnt_d    = cnt_q + CntW'(1);
        if (mem_err) begin
          state_d = StDone;
          req_d   = 1'b0;
          fault_d = 1'b1;
          ldata_d = '0;
        end else if (mem_ack) begin
          state_d = StDone;
          req_d   = 1'b0;
          if (!we_q) begin
            ldata_d  = ext_data;
            lvalid_d = 1'b1;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          req_d   = 1'b0;
          fault_d = 1'b1;
          ldata_d = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      f3_q     <= '0;
      lane_q   <= '0;
      ldata_q  <= '0;
      lvalid_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      f3_q     <= f3_d;
      lane_q   <= lane_d;
      ldata_q  <= ldata_d;
      lvalid_q <= lvalid_d;
      fault_q  <= fault_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;
  assign load_data  = ldata_q;
  assign load_valid = lvalid_q;
  assign bus_fault  = fault_q;

endmodule
